// File: rtl/pong_match_controller.sv
// ---------------------------------------------------------------------------
// pong_match_controller
//
// Match sequencer for Pong. It sits between the bounce/collision detector and
// the ball/paddle motion blocks. It turns the level-type "ball out" bounce code
// into exactly one point per rally and owns both scores. It also runs the serve
// countdown, pause, post-point freeze and win detection.
//
// Ports:
//   clock          in   system clock, all logic on posedge
//   reset          in   synchronous, active-high reset
//   frame_tick     in   one-cycle pulse per video frame
//   start_button   in   debounced level; only rising edges act
//   pause_button   in   debounced level; only rising edges act
//   bounce[1:0]    in   00 none, 01 paddle, 10 wall, 11 ball out
//   ball_pos_x[9:0]in   current ball x position
//   ball_enable    out  ball may move
//   ball_reset     out  hold ball at centre
//   paddle_enable  out  paddles may move
//   serve_dir      out  0 = toward player 1 (left), 1 = toward player 2 (right)
//   score_player_1 out  player 1 score
//   score_player_2 out  player 2 score
//   point_pulse    out  one-cycle pulse when a point is awarded
//   game_over      out  match finished
//   winner[1:0]    out  00 none, 01 player 1, 10 player 2
//   state[2:0]     out  debug: IDLE=0 SERVE=1 PLAY=2 PAUSED=3 POINT=4 GAME_OVER=5
//
// All outputs are registered. They change on the clock edge that takes the
// transition.
// ---------------------------------------------------------------------------
module pong_match_controller #(
    parameter int SCREEN_X     = 640,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_button,
    input  logic       pause_button,
    input  logic [1:0] bounce,
    input  logic [9:0] ball_pos_x,
    output logic       ball_enable,
    output logic       ball_reset,
    output logic       paddle_enable,
    output logic       serve_dir,
    output logic [3:0] score_player_1,
    output logic [3:0] score_player_2,
    output logic       point_pulse,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_POINT     = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    localparam logic [9:0] MIDLINE    = 10'(SCREEN_X / 2);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] WIN_VALUE  = 4'(WIN_SCORE);

    state_t     r_state;
    logic [7:0] r_count;
    logic [3:0] r_score1;
    logic [3:0] r_score2;
    logic       r_serve_dir;
    logic       r_point_pulse;
    logic [1:0] r_winner;
    logic       r_game_over;
    logic       r_ball_enable;
    logic       r_ball_reset;
    logic       r_paddle_enable;
    logic       r_start_q;
    logic       r_pause_q;

    state_t     w_state_next;
    logic [7:0] w_count_next;
    logic [3:0] w_score1_next;
    logic [3:0] w_score2_next;
    logic       w_serve_dir_next;
    logic       w_point_pulse_next;
    logic [1:0] w_winner_next;
    logic       w_game_over_next;
    logic       w_ball_enable_next;
    logic       w_ball_reset_next;
    logic       w_paddle_enable_next;

    logic       w_start_rise;
    logic       w_pause_rise;
    logic [3:0] w_score1_inc;
    logic [3:0] w_score2_inc;

    assign w_start_rise = start_button & ~r_start_q;
    assign w_pause_rise = pause_button & ~r_pause_q;

    // Saturating increments; 15 is only reachable if WIN_SCORE is out of range.
    assign w_score1_inc = (r_score1 == 4'hF) ? 4'hF : r_score1 + 4'd1;
    assign w_score2_inc = (r_score2 == 4'hF) ? 4'hF : r_score2 + 4'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_count         <= 8'd0;
            r_score1        <= 4'd0;
            r_score2        <= 4'd0;
            r_serve_dir     <= 1'b0;
            r_point_pulse   <= 1'b0;
            r_winner        <= 2'b00;
            r_game_over     <= 1'b0;
            r_ball_enable   <= 1'b0;
            r_ball_reset    <= 1'b1;
            r_paddle_enable <= 1'b0;
            r_start_q       <= 1'b0;
            r_pause_q       <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_count         <= w_count_next;
            r_score1        <= w_score1_next;
            r_score2        <= w_score2_next;
            r_serve_dir     <= w_serve_dir_next;
            r_point_pulse   <= w_point_pulse_next;
            r_winner        <= w_winner_next;
            r_game_over     <= w_game_over_next;
            r_ball_enable   <= w_ball_enable_next;
            r_ball_reset    <= w_ball_reset_next;
            r_paddle_enable <= w_paddle_enable_next;
            r_start_q       <= start_button;
            r_pause_q       <= pause_button;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_count_next       = r_count;
        w_score1_next      = r_score1;
        w_score2_next      = r_score2;
        w_serve_dir_next   = r_serve_dir;
        w_point_pulse_next = 1'b0;
        w_winner_next      = r_winner;

        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_next  = ST_SERVE;
                    w_score1_next = 4'd0;
                    w_score2_next = 4'd0;
                    w_count_next  = 8'd0;
                end
            end

            ST_SERVE: begin
                if (frame_tick) begin
                    if (r_count == SERVE_LAST) begin
                        w_state_next = ST_PLAY;
                        w_count_next = 8'd0;
                    end else begin
                        w_count_next = r_count + 8'd1;
                    end
                end
            end

            ST_PLAY: begin
                // Ball-out outranks a simultaneous pause press. Leaving PLAY in
                // the same cycle is what limits a held bounce code to one point.
                if (bounce == 2'b11) begin
                    w_point_pulse_next = 1'b1;
                    w_count_next       = 8'd0;
                    if (ball_pos_x >= MIDLINE) begin
                        w_score1_next    = w_score1_inc;
                        w_serve_dir_next = 1'b1;
                        if (w_score1_inc == WIN_VALUE) begin
                            w_state_next  = ST_GAME_OVER;
                            w_winner_next = 2'b01;
                        end else begin
                            w_state_next = ST_POINT;
                        end
                    end else begin
                        w_score2_next    = w_score2_inc;
                        w_serve_dir_next = 1'b0;
                        if (w_score2_inc == WIN_VALUE) begin
                            w_state_next  = ST_GAME_OVER;
                            w_winner_next = 2'b10;
                        end else begin
                            w_state_next = ST_POINT;
                        end
                    end
                end else if (w_pause_rise) begin
                    w_state_next = ST_PAUSED;
                end
            end

            ST_PAUSED: begin
                if (w_pause_rise) begin
                    w_state_next = ST_PLAY;
                end
            end

            ST_POINT: begin
                if (frame_tick) begin
                    if (r_count == POINT_LAST) begin
                        w_state_next = ST_SERVE;
                        w_count_next = 8'd0;
                    end else begin
                        w_count_next = r_count + 8'd1;
                    end
                end
            end

            ST_GAME_OVER: begin
                // serve_dir is kept, so the loser of the last point serves first.
                if (w_start_rise) begin
                    w_state_next  = ST_SERVE;
                    w_score1_next = 4'd0;
                    w_score2_next = 4'd0;
                    w_winner_next = 2'b00;
                    w_count_next  = 8'd0;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_count_next = 8'd0;
            end
        endcase

        // Outputs follow the state being entered, so they line up with r_state.
        w_ball_enable_next   = (w_state_next == ST_PLAY);
        w_ball_reset_next    = (w_state_next == ST_IDLE) || (w_state_next == ST_SERVE);
        w_paddle_enable_next = (w_state_next == ST_SERVE) || (w_state_next == ST_PLAY) ||
                               (w_state_next == ST_POINT);
        w_game_over_next     = (w_state_next == ST_GAME_OVER);
    end

    assign ball_enable    = r_ball_enable;
    assign ball_reset     = r_ball_reset;
    assign paddle_enable  = r_paddle_enable;
    assign serve_dir      = r_serve_dir;
    assign score_player_1 = r_score1;
    assign score_player_2 = r_score2;
    assign point_pulse    = r_point_pulse;
    assign game_over      = r_game_over;
    assign winner         = r_winner;
    assign state          = r_state;

endmodule

// File: tb/tb_pong_match_controller.sv
// Testbench for pong_match_controller with WIN_SCORE=3, SERVE_FRAMES=3 and
// POINT_FRAMES=2. The stimulus pushes the expected snapshot of every output
// event (state change or point_pulse) into exp_q. A monitor on the falling
// edge pops the queue and compares each event it sees.
module tb_pong_match_controller;

  // Snapshot layout: {state[2:0], s1[3:0], s2[3:0], serve_dir, ball_enable,
  //                   ball_reset, paddle_enable, point_pulse, game_over, winner[1:0]}
  localparam int W = 19;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                         S_PAUSED = 3'd3, S_POINT = 3'd4, S_GO = 3'd5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_button = 1'b0;
  logic       pause_button = 1'b0;
  logic [1:0] bounce = 2'b00;
  logic [9:0] ball_pos_x = 10'd320;
  logic       ball_enable, ball_reset, paddle_enable, serve_dir;
  logic [3:0] score_player_1, score_player_2;
  logic       point_pulse, game_over;
  logic [1:0] winner;
  logic [2:0] state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_pulses = 0;
  logic mon_en = 1'b0;
  logic [2:0] prev_state = 3'd0;

  pong_match_controller #(
    .SCREEN_X(640), .WIN_SCORE(3), .SERVE_FRAMES(3), .POINT_FRAMES(2)
  ) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .start_button(start_button), .pause_button(pause_button),
    .bounce(bounce), .ball_pos_x(ball_pos_x),
    .ball_enable(ball_enable), .ball_reset(ball_reset),
    .paddle_enable(paddle_enable), .serve_dir(serve_dir),
    .score_player_1(score_player_1), .score_player_2(score_player_2),
    .point_pulse(point_pulse), .game_over(game_over),
    .winner(winner), .state(state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, queued=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [3:0] s1,
                                      input logic [3:0] s2, input logic sd,
                                      input logic be, input logic br, input logic pe,
                                      input logic pp, input logic go, input logic [1:0] wn);
    mk = {st, s1, s2, sd, be, br, pe, pp, go, wn};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = {state, score_player_1, score_player_2, serve_dir, ball_enable,
           ball_reset, paddle_enable, point_pulse, game_over, winner};
    if (mon_en && (point_pulse === 1'b1 || state !== prev_state)) begin
      if (point_pulse === 1'b1) n_pulses++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got 0x%0h, expected no event", act);
      end else begin
        exp = exp_q.pop_front();
        check("event_snapshot", 32'(act), 32'(exp));
      end
    end
    prev_state = state;
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(1);
    #3;
    check("reset_state", 32'(state), 32'(S_IDLE));
    check("reset_score1", 32'(score_player_1), 32'd0);
    check("reset_score2", 32'(score_player_2), 32'd0);
    check("reset_ball_reset", 32'(ball_reset), 32'd1);
    check("reset_ball_enable", 32'(ball_enable), 32'd0);
    check("reset_paddle_enable", 32'(paddle_enable), 32'd0);
    check("reset_game_over", 32'(game_over), 32'd0);
    check("reset_winner", 32'(winner), 32'd0);
    check("reset_serve_dir", 32'(serve_dir), 32'd0);
    check("reset_point_pulse", 32'(point_pulse), 32'd0);
    mon_en = 1'b1;

    // IDLE ignores frame ticks and ball-out.
    bounce = 2'b11;
    repeat (4) tick();
    bounce = 2'b00;
    cyc(1);
    #3;
    check("idle_hold_state", 32'(state), 32'(S_IDLE));

    // Start rise -> SERVE. Start stays held: no second transition.
    exp_q.push_back(mk(S_SERVE, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00));
    start_button = 1'b1;
    cyc(1);
    tick();
    tick();
    exp_q.push_back(mk(S_PLAY, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00));
    tick();
    cyc(3);
    start_button = 1'b0;
    cyc(1);

    // Right-side ball-out held 500 cycles: one point to player 1.
    ball_pos_x = 10'd630;
    exp_q.push_back(mk(S_POINT, 1, 0, 1, 0, 0, 1, 1, 0, 2'b00));
    bounce = 2'b11;
    cyc(500);
    tick();
    exp_q.push_back(mk(S_SERVE, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00));
    tick();
    bounce = 2'b00;
    tick();
    tick();
    exp_q.push_back(mk(S_PLAY, 1, 0, 1, 1, 0, 1, 0, 0, 2'b00));
    tick();

    // Left-side point: player 2 scores, serve toward player 1.
    ball_pos_x = 10'd3;
    exp_q.push_back(mk(S_POINT, 1, 1, 0, 0, 0, 1, 1, 0, 2'b00));
    bounce = 2'b11;
    cyc(1);
    bounce = 2'b00;
    tick();
    exp_q.push_back(mk(S_SERVE, 1, 1, 0, 0, 1, 1, 0, 0, 2'b00));
    tick();
    tick();
    tick();
    exp_q.push_back(mk(S_PLAY, 1, 1, 0, 1, 0, 1, 0, 0, 2'b00));
    tick();

    // Pause, ball-out while paused, start rise while paused, resume.
    exp_q.push_back(mk(S_PAUSED, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00));
    pause_button = 1'b1;
    cyc(1);
    pause_button = 1'b0;
    bounce = 2'b11;
    cyc(5);
    start_button = 1'b1;
    cyc(1);
    start_button = 1'b0;
    bounce = 2'b00;
    cyc(2);
    exp_q.push_back(mk(S_PLAY, 1, 1, 0, 1, 0, 1, 0, 0, 2'b00));
    pause_button = 1'b1;
    cyc(1);
    pause_button = 1'b0;
    cyc(2);

    // Pause rise and ball-out together: the point wins.
    exp_q.push_back(mk(S_POINT, 1, 2, 0, 0, 0, 1, 1, 0, 2'b00));
    pause_button = 1'b1;
    bounce = 2'b11;
    cyc(1);
    pause_button = 1'b0;
    bounce = 2'b00;
    tick();
    exp_q.push_back(mk(S_SERVE, 1, 2, 0, 0, 1, 1, 0, 0, 2'b00));
    tick();
    tick();
    tick();
    exp_q.push_back(mk(S_PLAY, 1, 2, 0, 1, 0, 1, 0, 0, 2'b00));
    tick();

    // Player 2 reaches 3 and wins.
    exp_q.push_back(mk(S_GO, 1, 3, 0, 0, 0, 0, 1, 1, 2'b10));
    bounce = 2'b11;
    cyc(1);
    bounce = 2'b00;
    repeat (3) tick();
    #3;
    check("game_over_winner_held", 32'(winner), 32'd2);
    check("game_over_level", 32'(game_over), 32'd1);

    // Restart from GAME_OVER.
    exp_q.push_back(mk(S_SERVE, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00));
    start_button = 1'b1;
    cyc(1);
    start_button = 1'b0;
    tick();
    tick();
    exp_q.push_back(mk(S_PLAY, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00));
    tick();

    // Right-side point, then back to PLAY, then reset mid-PLAY.
    ball_pos_x = 10'd320;
    exp_q.push_back(mk(S_POINT, 1, 0, 1, 0, 0, 1, 1, 0, 2'b00));
    bounce = 2'b11;
    cyc(1);
    bounce = 2'b00;
    tick();
    exp_q.push_back(mk(S_SERVE, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00));
    tick();
    tick();
    tick();
    exp_q.push_back(mk(S_PLAY, 1, 0, 1, 1, 0, 1, 0, 0, 2'b00));
    tick();
    exp_q.push_back(mk(S_IDLE, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00));
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(4);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("point_pulse_count", 32'(n_pulses), 32'd5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
